cla_seq_adder: RTL
==================

Name: cla_seq_adder

Overview:
Multi-cycle wide adder controller. It time-shares one Cla_16 slice across WORDS 16-bit chunks, least-significant chunk first. The carry is registered between chunks and the result is assembled in a register. It sits between a requester using a start/done handshake and a single Cla_16 instance inside this module, giving 16*WORDS-bit adds without replicating the CLA.

Parameters:
WORDS, 4, number of 16-bit chunks; operand width W = 16*WORDS; legal range 2..8.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  W  operand A; captured on the accepted start
b  input  W  operand B; captured on the accepted start
cin  input  1  carry-in to chunk 0; captured on the accepted start
op_sub  input  1  subtract select; used only with CLA_SEQ_SUB_EN
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
sum  output  W  result register, held until the next accepted start
cout  output  1  carry out of the top chunk
ovf  output  1  two's-complement overflow of the W-bit result

Behaviour:
- Reset (async, any state): state=IDLE. busy=0, done=0, sum=0, cout=0, ovf=0. Chunk index=0, carry reg=0, operand regs=0.
- States:
  - IDLE: start=1 at an edge latches a, b, cin into registers; carry reg<=cin; idx<=0; state<=RUN. start=0 stays in IDLE.
  - RUN: busy=1. The Cla_16 is fed x=A[16*idx+:16], y=B[16*idx+:16], c0=carry reg. At each edge: sum[16*idx+:16]<=s; carry reg<=c16; idx<=idx+1. When idx==WORDS-1: cout<=c16, ovf computed, state<=DONE.
  - DONE: done=1 for exactly one cycle; busy=0; then unconditionally to IDLE.
- Latency: start accepted at edge 0; chunks processed at edges 1..WORDS; done high in the cycle after edge WORDS. Back-to-back: the earliest next accept is the edge that leaves DONE+1, i.e. start must be seen in IDLE.
- start in RUN or DONE is ignored; it is not queued, and operands are not re-sampled.
- ovf = (A[W-1] == Beff[W-1]) && (s[15] of top chunk != A[W-1]). Beff is B, or ~B when subtracting.
- sum bits are updated chunk by chunk during RUN. Consumers read sum only when done=1 or afterwards in IDLE.
- sum, cout and ovf hold in IDLE until the next accepted start. The accept itself does not clear them; chunks overwrite progressively.
- G/P outputs of Cla_16 are unused.
- Reset asserted mid-RUN aborts the operation. No done is pulsed. All outputs return to reset values.
- Counter width: clog2(WORDS), no wrap. idx is only compared to WORDS-1 in RUN.

Optional Feature:
Macro CLA_SEQ_SUB_EN.
- Defined: if op_sub=1 at accept, B is latched as ~b and carry reg<=1, with cin ignored. The result is A-B, and cout=1 means no borrow. op_sub=0 behaves as plain add.
- Undefined: the op_sub port still exists but is ignored; the block always adds.

Test Plan:
1. WORDS=4; a=0x0000_0000_0000_FFFF, b=1, cin=0, start pulse -> busy high 4 cycles; done pulse 4 cycles after accept edge; sum=0x0000_0000_0001_0000, cout=0, ovf=0.
2. a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> carry ripples through all chunks; sum=0, cout=1, ovf=0. Then a=6, b=9, cin=1 -> sum=0x10, cout=0.
3. a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
4. Accept a=1, b=2; hold start=1 with a=5, b=5 during RUN -> done once with sum=3. Another accept follows only after returning to IDLE, giving sum=0xA.
5. Accept a=0xFFFF_FFFF_FFFF_FFFF, b=1; assert rst at the 2nd RUN cycle -> busy=0, sum=0, cout=0 immediately; no done pulse. After release, idle with outputs zero.
6. CLA_SEQ_SUB_EN defined: a=5, b=7, op_sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. a=7, b=5 -> sum=2, cout=1. Undefined: a=5, b=7, op_sub=1 -> sum=0xC.

Source files
------------

// File: rtl/cla_seq_adder.sv
// ============================================================================
//  Module      : cla_seq_adder (with helper Cla_16)
//  Description : Multi-cycle 16*WORDS-bit adder that time-shares a single
//                16-bit carry-lookahead slice, least-significant chunk first,
//                behind a start/done handshake.
//                Optional macro CLA_SEQ_SUB_EN enables subtract via i_op_sub.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// 16-bit two-level carry-lookahead slice (4 groups of 4 bits).
module Cla_16 (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_c0,
    output logic [15:0] o_s,
    output logic        o_c16,
    output logic        o_g,
    output logic        o_p
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_gg;
    logic [3:0]  w_pg;
    logic [3:0]  w_cg;

    assign w_g = i_x & i_y;
    assign w_p = i_x ^ i_y;

    // Group generate/propagate and in-group carries from the group carry-in
    for (genvar k = 0; k < 4; k++) begin : g_grp
        assign w_gg[k] = w_g[4*k+3]
                       | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
        assign w_pg[k] = &w_p[4*k +: 4];

        assign w_c[4*k]   = w_cg[k];
        assign w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_cg[k]);
        assign w_c[4*k+2] = w_g[4*k+1]
                          | (w_p[4*k+1] & w_g[4*k])
                          | (w_p[4*k+1] & w_p[4*k] & w_cg[k]);
        assign w_c[4*k+3] = w_g[4*k+2]
                          | (w_p[4*k+2] & w_g[4*k+1])
                          | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                          | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_cg[k]);
    end

    // Second-level lookahead across the four groups
    assign w_cg[0] = i_c0;
    assign w_cg[1] = w_gg[0] | (w_pg[0] & i_c0);
    assign w_cg[2] = w_gg[1] | (w_pg[1] & w_gg[0]) | (w_pg[1] & w_pg[0] & i_c0);
    assign w_cg[3] = w_gg[2] | (w_pg[2] & w_gg[1]) | (w_pg[2] & w_pg[1] & w_gg[0])
                   | (w_pg[2] & w_pg[1] & w_pg[0] & i_c0);

    assign o_g   = w_gg[3] | (w_pg[3] & w_gg[2]) | (w_pg[3] & w_pg[2] & w_gg[1])
                 | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0]);
    assign o_p   = &w_pg;
    assign o_c16 = o_g | (o_p & i_c0);
    assign o_s   = w_p ^ w_c;
endmodule

module cla_seq_adder #(
    parameter  int WORDS = 4,
    localparam int W     = 16 * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    input  logic         i_op_sub,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_ovf
);
    localparam int                 c_IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_carry;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_sum;
    logic                r_busy;
    logic                r_done;
    logic                r_cout;
    logic                r_ovf;

    logic [15:0]         w_x;
    logic [15:0]         w_y;
    logic [15:0]         w_s;
    logic                w_c16;
    logic                w_g_unused;
    logic                w_p_unused;
    logic                w_sub;

`ifdef CLA_SEQ_SUB_EN
    assign w_sub = i_op_sub;
`else
    // Subtract support is compiled out; the port is kept for a stable interface.
    logic w_op_sub_unused;
    assign w_op_sub_unused = i_op_sub;
    assign w_sub           = 1'b0;
`endif

    // Current chunk of each operand; B is already inverted when subtracting
    assign w_x = r_a[{r_idx, 4'b0000} +: 16];
    assign w_y = r_b[{r_idx, 4'b0000} +: 16];

    Cla_16 u_cla (
        .i_x   (w_x),
        .i_y   (w_y),
        .i_c0  (r_carry),
        .o_s   (w_s),
        .o_c16 (w_c16),
        .o_g   (w_g_unused),
        .o_p   (w_p_unused)
    );

    // Controller: accept in IDLE, one chunk per cycle in RUN, one-cycle DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= w_sub ? ~i_b : i_b;
                        r_carry <= w_sub ? 1'b1 : i_cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[{r_idx, 4'b0000} +: 16] <= w_s;
                    r_carry <= w_c16;
                    if (r_idx == c_LAST) begin
                        r_cout  <= w_c16;
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_s[15] != r_a[W-1]);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;
endmodule

`default_nettype wire
